kl8e_rx_ctrl: RTL and testbench

Console keyboard controller: PDP-8/E KL8E receive side, device code 03.
- Sits between the serial receiver datapath and the CPU IOT bus.
- Captures each received character into a holding buffer and maintains the keyboard flag, interrupt enable and error status.
- Decodes keyboard IOTs and returns AC data and skip.

---
 rtl/kl8e_rx_ctrl.sv | 144 ++++++++++++++
 tb/tb_kl8e_rx_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/kl8e_rx_ctrl.sv
// PDP-8/E KL8E console keyboard (receive) controller, IOT device 03.
// Define KL8E_RX_FIFO_EN to replace the single holding buffer with a FIFO_DEPTH-entry FIFO.
module kl8e_rx_ctrl #(
  parameter logic [5:0] DEVICE     = 6'o03,
  parameter logic       IE_RESET   = 1'b1,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        rx_frame_err,
  input  logic        iot_strobe,
  input  logic [11:0] instruction,
  input  logic [11:0] ac_in,
  output logic [11:0] ac_out,
  output logic        ac_clear,
  output logic        ac_or,
  output logic        skip,
  output logic        irq,
  output logic [2:0]  status
);

  typedef enum logic [2:0] {
    FN_KCF = 3'd0, FN_KSF = 3'd1, FN_KCC = 3'd2, FN_NOP3 = 3'd3,
    FN_KRS = 3'd4, FN_KIE = 3'd5, FN_KRB = 3'd6, FN_NOP7 = 3'd7
  } kbd_fn_e;

  kbd_fn_e    fn;
  logic       iot_hit;
  logic       do_clear_flag;
  logic       do_read;
  logic       do_krb;
  logic       flag;
  logic       ie;
  logic       overrun;
  logic       frame_bit;
  logic [7:0] rd_char;
  logic       unused_ac_bits;

  assign fn            = kbd_fn_e'(instruction[2:0]);
  assign iot_hit       = iot_strobe && (instruction[11:9] == 3'o6) && (instruction[8:3] == DEVICE);
  assign do_clear_flag = iot_hit && (fn == FN_KCF || fn == FN_KCC || fn == FN_KRB);
  assign do_read       = iot_hit && (fn == FN_KRS || fn == FN_KRB);
  assign do_krb        = iot_hit && (fn == FN_KRB);
  assign unused_ac_bits = ^ac_in[11:1];

  // CPU-facing responses: registered, valid only in the cycle after the IOT.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk100) begin
    if (reset) begin
      ie       <= IE_RESET;
      ac_out   <= 12'o0000;
      ac_clear <= 1'b0;
      ac_or    <= 1'b0;
      skip     <= 1'b0;
    end else begin
      ac_out   <= do_read ? {4'b0000, rd_char} : 12'o0000;
      ac_or    <= do_read;
      ac_clear <= iot_hit && (fn == FN_KCC || fn == FN_KRB);
      skip     <= iot_hit && (fn == FN_KSF) && flag;
      if (iot_hit && fn == FN_KIE) ie <= ac_in[0];
    end
  end

  assign irq    = flag & ie;
  assign status = {overrun, frame_bit, flag};

`ifdef KL8E_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic [8:0]    head;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  // Any flag-clearing IOT consumes the head; a full FIFO still accepts a push that pairs with a pop.
  assign pop   = do_clear_flag && !empty;
  assign push  = rx_strobe && (!full || pop);
  assign head  = mem[rd_ptr];

  assign flag      = !empty;
  assign frame_bit = !empty && head[8];
  assign rd_char   = empty ? 8'h00 : head[7:0];

  // NOTE: storage is deliberately not reset; the count gates every read of it.
  always_ff @(posedge clk100) begin
    if (push && !reset) mem[wr_ptr] <= {rx_frame_err, rx_data};
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (do_krb) overrun <= 1'b0;
      if (rx_strobe && full && !pop) overrun <= 1'b1;
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [7:0] buffer;
  logic       frame_err;

  assign frame_bit = frame_err;
  assign rd_char   = buffer;

  always_ff @(posedge clk100) begin
    if (reset) begin
      flag      <= 1'b0;
      buffer    <= 8'h00;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_clear_flag) flag <= 1'b0;
      if (do_krb) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      // NOTE: the last non-blocking assignment wins, so a same-cycle character overrides the clears above.
      if (rx_strobe) begin
        buffer    <= rx_data;
        flag      <= 1'b1;
        frame_err <= rx_frame_err | (frame_err & !do_krb);
        if (flag && !do_clear_flag) overrun <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_kl8e_rx_ctrl.sv
// Directed self-checking bench for kl8e_rx_ctrl; FIFO scenario runs when KL8E_RX_FIFO_EN is defined.
`timescale 1ns/1ps
module tb_kl8e_rx_ctrl;

  logic        clk100 = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic        rx_frame_err;
  logic        iot_strobe;
  logic [11:0] instruction;
  logic [11:0] ac_in;
  logic [11:0] ac_out;
  logic        ac_clear;
  logic        ac_or;
  logic        skip;
  logic        irq;
  logic [2:0]  status;

  int checks = 0;
  int errors = 0;

  kl8e_rx_ctrl dut (
    .clk100       (clk100),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_strobe    (rx_strobe),
    .rx_frame_err (rx_frame_err),
    .iot_strobe   (iot_strobe),
    .instruction  (instruction),
    .ac_in        (ac_in),
    .ac_out       (ac_out),
    .ac_clear     (ac_clear),
    .ac_or        (ac_or),
    .skip         (skip),
    .irq          (irq),
    .status       (status)
  );

  always #5 clk100 = ~clk100;

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic rx(input logic [7:0] data, input logic fe);
    rx_data = data; rx_frame_err = fe; rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0; rx_frame_err = 1'b0;
  endtask

  task automatic iot(input logic [11:0] instr, input logic [11:0] acv);
    instruction = instr; ac_in = acv; iot_strobe = 1'b1;
    tick();
    iot_strobe = 1'b0;
  endtask

  task automatic rx_and_iot(input logic [7:0] data, input logic [11:0] instr);
    rx_data = data; rx_frame_err = 1'b0; rx_strobe = 1'b1;
    instruction = instr; ac_in = 12'o0000; iot_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0; iot_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_data = 8'h00; rx_strobe = 1'b0; rx_frame_err = 1'b0;
    iot_strobe = 1'b0; instruction = 12'o0000; ac_in = 12'o0000;
    tick(); tick();
    rx_data = 8'h55; rx_strobe = 1'b1; rx_frame_err = 1'b1;
    tick();
    reset = 1'b0; rx_strobe = 1'b0; rx_frame_err = 1'b0;
    repeat (10) tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", irq); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", status); end
    checks++; if ({ac_out, ac_clear, ac_or, skip} !== 15'd0) begin errors++; $display("FAIL reset_outputs: ac_out=%o clr=%0b or=%0b skip=%0b want all 0", ac_out, ac_clear, ac_or, skip); end
    iot(12'o6031, 12'o0000);
    checks++; if (skip !== 1'b0) begin errors++; $display("FAIL reset_ksf_skip: got %0b want 0", skip); end
  endtask

  task automatic test_capture();
    rx(8'h41, 1'b0);
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL cap_status: got %b want 001", status); end
    iot(12'o6031, 12'o0000);
    checks++; if (skip !== 1'b1) begin errors++; $display("FAIL cap_ksf_skip: got %0b want 1", skip); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cap_irq: got %0b want 1", irq); end
    tick();
    checks++; if (skip !== 1'b0) begin errors++; $display("FAIL cap_skip_one_cycle: got %0b want 0", skip); end
    iot(12'o6036, 12'o0000);
    checks++; if ({ac_clear, ac_or} !== 2'b11) begin errors++; $display("FAIL cap_krb_ctl: got clr=%0b or=%0b want 1 1", ac_clear, ac_or); end
    checks++; if (ac_out !== 12'o0101) begin errors++; $display("FAIL cap_krb_data: got %o want 0101", ac_out); end
    checks++; if (status !== 3'b000 || irq !== 1'b0) begin errors++; $display("FAIL cap_after_krb: status=%b irq=%0b want 000 0", status, irq); end
    tick();
    checks++; if ({ac_out, ac_clear, ac_or} !== 14'd0) begin errors++; $display("FAIL cap_resp_one_cycle: ac_out=%o clr=%0b or=%0b want 0", ac_out, ac_clear, ac_or); end
  endtask

  task automatic test_overrun();
    rx(8'h31, 1'b0);
    rx(8'h32, 1'b0);
    checks++; if (status !== 3'b101) begin errors++; $display("FAIL ovr_status: got %b want 101", status); end
    iot(12'o6036, 12'o0000);
    checks++; if (ac_out !== 12'o0062) begin errors++; $display("FAIL ovr_krb_data: got %o want 0062", ac_out); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL ovr_after_krb: got %b want 000", status); end
  endtask

  task automatic test_ie();
    iot(12'o6035, 12'o0000);
    rx(8'h0D, 1'b0);
    checks++; if (status[0] !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL ie_off: flag=%0b irq=%0b want 1 0", status[0], irq); end
    iot(12'o6035, 12'o0001);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ie_on_irq: got %0b want 1", irq); end
    iot(12'o6036, 12'o0000);
    checks++; if (ac_out !== 12'o0015) begin errors++; $display("FAIL ie_krb_data: got %o want 0015", ac_out); end
  endtask

  task automatic test_simultaneous();
    rx(8'h55, 1'b0);
    rx_and_iot(8'h7A, 12'o6030);
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL sim_kcf_status: got %b want 001", status); end
    iot(12'o6034, 12'o0000);
    checks++; if (ac_out !== 12'o0172 || ac_or !== 1'b1 || ac_clear !== 1'b0) begin errors++; $display("FAIL sim_krs: ac_out=%o or=%0b clr=%0b want 0172 1 0", ac_out, ac_or, ac_clear); end
    checks++; if (status[0] !== 1'b1) begin errors++; $display("FAIL sim_krs_flag: got %0b want 1", status[0]); end
    rx(8'h13, 1'b1);
    checks++; if (status !== 3'b111) begin errors++; $display("FAIL sim_fe_status: got %b want 111", status); end
    iot(12'o6030, 12'o0000);
    checks++; if (status !== 3'b110) begin errors++; $display("FAIL sim_fe_sticky: got %b want 110", status); end
    iot(12'o6036, 12'o0000);
    checks++; if (ac_out !== 12'o0023 || status !== 3'b000) begin errors++; $display("FAIL sim_fe_krb: ac_out=%o status=%b want 0023 000", ac_out, status); end
  endtask

  task automatic test_back_to_back();
    rx(8'h41, 1'b0);
    instruction = 12'o6031; ac_in = 12'o0000; iot_strobe = 1'b1;
    tick();
    checks++; if (skip !== 1'b1) begin errors++; $display("FAIL b2b_ksf: got %0b want 1", skip); end
    instruction = 12'o6036;
    tick();
    iot_strobe = 1'b0;
    checks++; if (skip !== 1'b0 || ac_or !== 1'b1 || ac_out !== 12'o0101) begin errors++; $display("FAIL b2b_krb: skip=%0b or=%0b ac_out=%o want 0 1 0101", skip, ac_or, ac_out); end
    rx(8'h41, 1'b0);
    rx_and_iot(8'h42, 12'o6036);
    checks++; if (ac_out !== 12'o0101 || status !== 3'b001) begin errors++; $display("FAIL b2b_krb_with_rx: ac_out=%o status=%b want 0101 001", ac_out, status); end
    iot(12'o6046, 12'o0000);
    checks++; if (ac_or !== 1'b0 || status[0] !== 1'b1) begin errors++; $display("FAIL b2b_other_device: or=%0b flag=%0b want 0 1", ac_or, status[0]); end
    iot(12'o6036, 12'o0000);
    checks++; if (ac_out !== 12'o0102 || status !== 3'b000) begin errors++; $display("FAIL b2b_second_krb: ac_out=%o status=%b want 0102 000", ac_out, status); end
  endtask

`ifdef KL8E_RX_FIFO_EN
  task automatic test_fifo();
    logic [11:0] want;
    for (int i = 1; i <= 5; i++) rx(8'(i), 1'b0);
    checks++; if (status !== 3'b101) begin errors++; $display("FAIL fifo_overrun: got %b want 101", status); end
    for (int i = 1; i <= 4; i++) begin
      iot(12'o6036, 12'o0000);
      want = 12'(i);
      checks++; if (ac_out !== want) begin errors++; $display("FAIL fifo_krb_%0d: got %o want %o", i, ac_out, want); end
    end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL fifo_drained: got %b want 000", status); end
    iot(12'o6031, 12'o0000);
    checks++; if (skip !== 1'b0) begin errors++; $display("FAIL fifo_ksf_empty: got %0b want 0", skip); end
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
`ifndef KL8E_RX_FIFO_EN
    test_overrun();
`endif
    test_ie();
`ifndef KL8E_RX_FIFO_EN
    test_simultaneous();
`endif
    test_back_to_back();
`ifdef KL8E_RX_FIFO_EN
    test_fifo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
